// File: rtl/alu_cond_unit_if.sv
// alu_cond_unit_if -- operand, control and result bundle of the ALU /
// condition unit.
//
// Signals
//   alu_a, alu_b   operand A (shifter operand) and operand B (Rn value)
//   alu_op         operation select
//   flag_ld        flag register load enable
//   cond           condition field (instruction bits 31:28)
//   ir_d, ir_ld    instruction register data in and load enable
//   alu_out        combinational ALU result
//   alu_flags      combinational flags {C,Z,V,N}
//   flags_q        registered flags {C,Z,V,N}
//   ir_q           instruction register contents
//   cond_true      condition evaluated against flags_q
//
// Modports
//   master  drives operands and controls, observes results
//   slave   the unit itself
interface alu_cond_unit_if;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic        flag_ld;
    logic [3:0]  cond;
    logic [31:0] ir_d;
    logic        ir_ld;
    logic [31:0] alu_out;
    logic [3:0]  alu_flags;
    logic [3:0]  flags_q;
    logic [31:0] ir_q;
    logic        cond_true;

    modport master (
        output alu_a, alu_b, alu_op, flag_ld, cond, ir_d, ir_ld,
        input  alu_out, alu_flags, flags_q, ir_q, cond_true
    );

    modport slave (
        input  alu_a, alu_b, alu_op, flag_ld, cond, ir_d, ir_ld,
        output alu_out, alu_flags, flags_q, ir_q, cond_true
    );
endinterface

// File: rtl/alu_cond_unit.sv
// alu_cond_unit -- 32-bit ARM-style ALU with a flag register, an instruction
// register and an ARM condition-code evaluator.
//
// Ports
//   CLK    system clock, all state updates on its rising edge
//   RESET  asynchronous, active-high reset of flags_q and ir_q
//   bus    alu_cond_unit_if.slave: operands, controls and results
//
// Flag vectors are ordered {C,Z,V,N}: bit3=C, bit2=Z, bit1=V, bit0=N.
module alu_cond_unit (
    input  logic            CLK,
    input  logic            RESET,
    alu_cond_unit_if.slave  bus
);

    typedef enum logic [4:0] {
        OP_AND      = 5'd0,  OP_EOR      = 5'd1,  OP_SUB      = 5'd2,
        OP_RSB      = 5'd3,  OP_ADD      = 5'd4,  OP_ADC      = 5'd5,
        OP_SBC      = 5'd6,  OP_RSC      = 5'd7,  OP_TST      = 5'd8,
        OP_TEQ      = 5'd9,  OP_CMP      = 5'd10, OP_CMN      = 5'd11,
        OP_ORR      = 5'd12, OP_MOV      = 5'd13, OP_BIC      = 5'd14,
        OP_MVN      = 5'd15, OP_PASS_A   = 5'd16, OP_ADDR_SUB = 5'd17,
        OP_A_INC4   = 5'd18, OP_ADDR_ADD = 5'd19, OP_PASS_B   = 5'd20,
        OP_B_INC4   = 5'd21, OP_B_DEC4   = 5'd22
    } alu_op_e;

    localparam logic [31:0] FOUR = 32'd4;

    // Flag bit positions.
    localparam int C_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int V_BIT = 1;
    localparam int N_BIT = 0;

    logic [3:0]  flags_r;
    logic [31:0] ir_r;
    logic        cin;

    // Every arithmetic op is mapped onto one adder: x + y + carry_in.
    // Subtraction feeds the inverted subtrahend with carry_in=1 (or Cin for
    // SBC/RSC), so the adder carry out is directly "not borrow".
    logic [31:0] op_x;
    logic [31:0] op_y;
    logic        op_cin;
    logic        is_arith;
    logic        is_valid;
    logic [32:0] sum;
    logic [31:0] result;

    assign cin = flags_r[C_BIT];

    // NOTE: every variable written in an always_comb gets a default at the
    // top, so no path through the case can leave it unassigned and infer a
    // latch.
    always_comb begin
        op_x     = '0;
        op_y     = '0;
        op_cin   = 1'b0;
        is_arith = 1'b0;
        is_valid = 1'b1;
        result   = '0;

        case (bus.alu_op)
            OP_AND, OP_TST: result = bus.alu_b & bus.alu_a;
            OP_EOR, OP_TEQ: result = bus.alu_b ^ bus.alu_a;
            OP_ORR:         result = bus.alu_b | bus.alu_a;
            OP_MOV,
            OP_PASS_A:      result = bus.alu_a;
            OP_BIC:         result = bus.alu_b & ~bus.alu_a;
            OP_MVN:         result = ~bus.alu_a;
            OP_PASS_B:      result = bus.alu_b;
            OP_SUB, OP_CMP, OP_ADDR_SUB: begin
                is_arith = 1'b1; op_x = bus.alu_b; op_y = ~bus.alu_a; op_cin = 1'b1;
            end
            OP_RSB: begin
                is_arith = 1'b1; op_x = bus.alu_a; op_y = ~bus.alu_b; op_cin = 1'b1;
            end
            OP_ADD, OP_CMN, OP_ADDR_ADD: begin
                is_arith = 1'b1; op_x = bus.alu_b; op_y = bus.alu_a;
            end
            OP_ADC: begin
                is_arith = 1'b1; op_x = bus.alu_b; op_y = bus.alu_a; op_cin = cin;
            end
            OP_SBC: begin
                is_arith = 1'b1; op_x = bus.alu_b; op_y = ~bus.alu_a; op_cin = cin;
            end
            OP_RSC: begin
                is_arith = 1'b1; op_x = bus.alu_a; op_y = ~bus.alu_b; op_cin = cin;
            end
            OP_A_INC4: begin
                is_arith = 1'b1; op_x = bus.alu_a; op_y = FOUR;
            end
            OP_B_INC4: begin
                is_arith = 1'b1; op_x = bus.alu_b; op_y = FOUR;
            end
            OP_B_DEC4: begin
                is_arith = 1'b1; op_x = bus.alu_b; op_y = ~FOUR; op_cin = 1'b1;
            end
            default: is_valid = 1'b0;
        endcase

        sum = {1'b0, op_x} + {1'b0, op_y} + {32'd0, op_cin};
        if (is_arith) begin
            result = sum[31:0];
        end
    end

    // Ops 23-31 are reserved: zero result, flags pass through unchanged.
    // Logic/move ops keep the registered C and V.
    always_comb begin
        bus.alu_out   = '0;
        bus.alu_flags = flags_r;
        if (is_valid) begin
            bus.alu_out            = result;
            bus.alu_flags[N_BIT]   = result[31];
            bus.alu_flags[Z_BIT]   = (result == 32'd0);
            if (is_arith) begin
                bus.alu_flags[C_BIT] = sum[32];
                // Overflow: both adder inputs share a sign the result lacks.
                bus.alu_flags[V_BIT] = (op_x[31] == op_y[31]) && (result[31] != op_x[31]);
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers sample their inputs from before the edge, independent of
    // process ordering.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flags_r <= '0;
            ir_r    <= '0;
        end else begin
            if (bus.flag_ld) flags_r <= bus.alu_flags;
            if (bus.ir_ld)   ir_r    <= bus.ir_d;
        end
    end

    assign bus.flags_q = flags_r;
    assign bus.ir_q    = ir_r;

    // Condition check uses only the registered flags, so a flag load in the
    // current cycle is visible only after the edge.
    always_comb begin
        logic c, z, v, n;
        c = flags_r[C_BIT];
        z = flags_r[Z_BIT];
        v = flags_r[V_BIT];
        n = flags_r[N_BIT];
        case (bus.cond)
            4'd0:    bus.cond_true = z;
            4'd1:    bus.cond_true = !z;
            4'd2:    bus.cond_true = c;
            4'd3:    bus.cond_true = !c;
            4'd4:    bus.cond_true = n;
            4'd5:    bus.cond_true = !n;
            4'd6:    bus.cond_true = v;
            4'd7:    bus.cond_true = !v;
            4'd8:    bus.cond_true = c && !z;
            4'd9:    bus.cond_true = !c || z;
            4'd10:   bus.cond_true = (n == v);
            4'd11:   bus.cond_true = (n != v);
            4'd12:   bus.cond_true = !z && (n == v);
            4'd13:   bus.cond_true = z || (n != v);
            4'd14:   bus.cond_true = 1'b1;
            default: bus.cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_cond_unit.sv
// tb_alu_cond_unit -- directed self-checking bench for alu_cond_unit.
// Expected values are hand-computed constants; flags are written {C,Z,V,N}.
module tb_alu_cond_unit;

    logic CLK;
    logic RESET;
    int   n_vec;
    int   n_fail;

    alu_cond_unit_if bus ();

    alu_cond_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.alu_op = op;
        bus.alu_a  = a;
        bus.alu_b  = b;
        #1;
    endtask

    logic [4:0]  addr_ops [5] = '{5'd17, 5'd19, 5'd21, 5'd22, 5'd18};
    logic [31:0] addr_exp [5] = '{32'h0000_00F8, 32'h0000_0108, 32'h0000_0104,
                                  32'h0000_00FC, 32'h0000_000C};

    initial begin
        n_vec      = 0;
        n_fail     = 0;
        RESET      = 1'b1;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_op = '0;
        bus.flag_ld = 1'b0;
        bus.cond   = 4'b0001;
        bus.ir_d   = '0;
        bus.ir_ld  = 1'b0;

        // Reset state, before any clock edge.
        #3;
        check("rst_ir_q", bus.ir_q, 32'h0);
        check("rst_flags_q", bus.flags_q, 4'b0000);
        check("rst_ne", bus.cond_true, 1'b1);
        bus.cond = 4'b1110; #1;
        check("rst_al", bus.cond_true, 1'b1);
        bus.cond = 4'b0000; #1;
        check("rst_eq", bus.cond_true, 1'b0);

        @(negedge CLK);
        RESET = 1'b0;

        // ADD overflowing into the sign bit; MI sees old flags until the edge.
        bus.flag_ld = 1'b1;
        bus.cond    = 4'b0100;
        set_op(5'd4, 32'h0000_000C, 32'h7FFF_FFF4);
        check("add_out", bus.alu_out, 32'h8000_0000);
        check("add_flags", bus.alu_flags, 4'b0011);
        check("mi_before_edge", bus.cond_true, 1'b0);
        tick();
        bus.flag_ld = 1'b0;
        check("add_flags_q", bus.flags_q, 4'b0011);
        check("mi_after_edge", bus.cond_true, 1'b1);
        bus.cond = 4'b1011; #1;
        check("lt_after_add", bus.cond_true, 1'b0);

        // flags_q = C0 Z0 V1 N0|1: logic ops keep C=0, V=1; SBC uses Cin=0.
        set_op(5'd13, 32'h0000_000C, 32'h0);
        check("mov_out_v1", bus.alu_out, 32'h0000_000C);
        check("mov_flags_v1", bus.alu_flags, 4'b0010);
        set_op(5'd6, 32'h0000_0002, 32'h0000_0005);
        check("sbc_out", bus.alu_out, 32'h0000_0002);
        check("sbc_flags", bus.alu_flags, 4'b1000);
        set_op(5'd23, 32'h1234_5678, 32'h9ABC_DEF0);
        check("op23_out", bus.alu_out, 32'h0);
        check("op23_flags", bus.alu_flags, 4'b0011);

        // SUB equal operands.
        bus.flag_ld = 1'b1;
        set_op(5'd2, 32'h5, 32'h5);
        check("sub_out", bus.alu_out, 32'h0);
        check("sub_flags", bus.alu_flags, 4'b1100);
        tick();
        bus.flag_ld = 1'b0;
        check("sub_flags_q", bus.flags_q, 4'b1100);
        bus.cond = 4'b0000; #1;
        check("eq_after_sub", bus.cond_true, 1'b1);
        bus.cond = 4'b1000; #1;
        check("hi_after_sub", bus.cond_true, 1'b0);
        bus.cond = 4'b1001; #1;
        check("ls_after_sub", bus.cond_true, 1'b1);

        // Flag register holds when flag_ld=0.
        set_op(5'd4, 32'h0000_000C, 32'h7FFF_FFF4);
        tick();
        check("flags_hold", bus.flags_q, 4'b1100);

        // flags_q = C1 Z1 V0 N0.
        set_op(5'd5, 32'hFFFF_FFFF, 32'h0);
        check("adc_out", bus.alu_out, 32'h0);
        check("adc_flags", bus.alu_flags, 4'b1100);
        set_op(5'd13, 32'h0000_000C, 32'h0);
        check("mov_out", bus.alu_out, 32'h0000_000C);
        check("mov_flags", bus.alu_flags, 4'b1000);
        set_op(5'd2, 32'h6, 32'h5);
        check("sub_borrow_out", bus.alu_out, 32'hFFFF_FFFF);
        check("sub_borrow_flags", bus.alu_flags, 4'b0001);
        set_op(5'd3, 32'h6, 32'h5);
        check("rsb_out", bus.alu_out, 32'h1);
        check("rsb_flags", bus.alu_flags, 4'b1000);
        set_op(5'd10, 32'h1, 32'h8000_0000);
        check("cmp_out", bus.alu_out, 32'h7FFF_FFFF);
        check("cmp_flags", bus.alu_flags, 4'b1010);
        set_op(5'd0, 32'h0000_00F0, 32'h0000_00FF);
        check("and_out", bus.alu_out, 32'h0000_00F0);
        check("and_flags", bus.alu_flags, 4'b1000);
        set_op(5'd15, 32'h0, 32'h0);
        check("mvn_out", bus.alu_out, 32'hFFFF_FFFF);
        check("mvn_flags", bus.alu_flags, 4'b1001);

        // Address ops, B=0x100, A=0x8.
        for (int i = 0; i < 5; i++) begin
            set_op(addr_ops[i], 32'h8, 32'h100);
            check($sformatf("addr_op%0d", addr_ops[i]), bus.alu_out, addr_exp[i]);
        end
        set_op(5'd22, 32'h8, 32'h100);
        check("b_dec4_flags", bus.alu_flags, 4'b1000);

        // Instruction register load, hold, async reset, reset priority.
        bus.ir_ld = 1'b1;
        bus.ir_d  = 32'hE1A0_800C;
        tick();
        check("ir_load", bus.ir_q, 32'hE1A0_800C);
        bus.ir_ld = 1'b0;
        bus.ir_d  = 32'h0;
        tick();
        check("ir_hold", bus.ir_q, 32'hE1A0_800C);
        #2;
        RESET = 1'b1;
        #1;
        check("ir_async_rst", bus.ir_q, 32'h0);
        check("flags_async_rst", bus.flags_q, 4'b0000);
        bus.ir_ld   = 1'b1;
        bus.ir_d    = 32'h1234_5678;
        bus.flag_ld = 1'b1;
        tick();
        check("ir_rst_override", bus.ir_q, 32'h0);
        check("flags_rst_override", bus.flags_q, 4'b0000);
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        check("ir_after_release", bus.ir_q, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cond_unit.md
ALU_COND_UNIT -- requirements
Module: alu_cond_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-003 RESET  input  1  reset, asynchronous, active-high.
REQ-004 alu_a  input  32  operand A, the shifter operand.
REQ-005 alu_b  input  32  operand B, the Rn value.
REQ-006 alu_op  input  5  operation select.
REQ-007 flag_ld  input  1  flag register load enable.
REQ-008 cond  input  4  condition field (instruction bits 31:28).
REQ-009 ir_d  input  32  instruction register data in.
REQ-010 ir_ld  input  1  instruction register load enable.
REQ-011 alu_out  output  32  combinational ALU result.
REQ-012 alu_flags  output  4  combinational flags {C,Z,V,N}: bit3=C, bit2=Z, bit1=V, bit0=N.
REQ-013 flags_q  output  4  registered flags, same bit order as alu_flags.
REQ-014 ir_q  output  32  instruction register contents.
REQ-015 cond_true  output  1  condition evaluated against flags_q.

Function
REQ-016 The ALU SHALL be purely combinational.
REQ-017 The ALU SHALL use Cin = flags_q[3].
REQ-018 alu_op 0-15 SHALL compute: 0 AND B&A; 1 EOR B^A; 2 SUB B-A; 3 RSB A-B; 4 ADD B+A; 5 ADC B+A+Cin; 6 SBC B-A-!Cin; 7 RSC A-B-!Cin; 8 TST B&A; 9 TEQ B^A; 10 CMP B-A; 11 CMN B+A; 12 ORR B|A; 13 MOV A; 14 BIC B&~A; 15 MVN ~A.
REQ-019 alu_op 16-22 SHALL compute: 16 pass A; 17 B-A; 18 A+4; 19 B+A; 20 pass B; 21 B+4; 22 B-4.
REQ-020 alu_op 23-31 SHALL drive alu_out=0 and set alu_flags=flags_q.
REQ-021 For TST/TEQ/CMP/CMN, alu_out SHALL still carry the computed result.
REQ-022 N SHALL equal result[31]; Z SHALL be 1 when result==0; this applies to all ops 0-22.
REQ-023 For addition ops, C SHALL be the carry out of bit 31.
REQ-024 For subtraction ops, C SHALL be NOT borrow (1 when no borrow).
REQ-025 For all arithmetic ops, V SHALL be signed two's-complement overflow of the 32-bit operation.
REQ-026 For logic and move ops (0,1,8,9,12-16,20), C SHALL equal flags_q[3] and V SHALL equal flags_q[1].
REQ-027 Sums SHALL wrap modulo 2^32.
REQ-028 The flag register SHALL capture alu_flags on a rising CLK edge when flag_ld=1, and hold otherwise.
REQ-029 The IR SHALL capture ir_d on a rising CLK edge when ir_ld=1, and hold otherwise.
REQ-030 cond_true SHALL be combinational from cond and flags_q using ARM encoding:
- 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
- 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V)
- 14 AL 1; 15 0
REQ-031 cond_true SHALL reflect the old flags during a cycle that loads the flags; the new flags affect it only after the edge.

Reset
REQ-032 While RESET=1, ir_q SHALL be 0 and flags_q SHALL be 0, immediately and without waiting for a clock edge.
REQ-033 RESET SHALL override ir_ld and flag_ld.
REQ-034 After reset with cond=1110, cond_true SHALL be 1; with cond=0000, cond_true SHALL be 0.
REQ-035 Deassertion of RESET SHALL take effect for the first rising edge after release.

Verification
REQ-036 Reset -> ir_q=0, flags_q=0; cond=0001 -> cond_true=1.
REQ-037 ADD, A=0x0000000C, B=0x7FFFFFF4, flag_ld=1, edge -> alu_out=0x80000000; flags_q: N=1, V=1, Z=0, C=0; cond=1011 (LT) -> cond_true=0.
REQ-038 SUB, A=5, B=5, flag_ld=1, edge -> alu_out=0, Z=1, C=1; cond=0000 -> cond_true=1; cond=1000 -> cond_true=0.
REQ-039 ADC with flags_q C=1, A=0xFFFFFFFF, B=0 -> alu_out=0, C=1, Z=1. MOV, A=0x0C -> alu_out=0x0C, and C and V keep their flags_q values.
REQ-040 Address ops, B=0x100, A=0x8:
- op17 -> 0xF8; op19 -> 0x108
- op21 -> 0x104; op22 -> 0xFC
- op18 -> 0x0C
REQ-041 IR hold and async reset:
- ir_ld=1, ir_d=0xE1A0800C, edge -> ir_q=0xE1A0800C
- ir_ld=0, next edge -> value held
- RESET pulsed mid-cycle -> ir_q=0 before the next edge
